// File: rtl/gh_ctrl_pkg.sv
// Shared definitions for the multicycle processor control unit.
//   state_e        : 4-bit FSM state encoding (also exported on the debug port)
//   OP_*           : 3-bit instruction opcodes
//   SRCB_*         : ALU operand-B select encodings
//   PCSRC_*        : next-PC source select encodings
//   ALUOP_*        : ALU-decoder class encodings
package gh_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_BGT   = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_JAL   = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;  // register B
    localparam logic [1:0] SRCB_FOUR  = 2'b01;  // constant 4 (PC increment)
    localparam logic [1:0] SRCB_IMM   = 2'b10;  // sign-extended immediate
    localparam logic [1:0] SRCB_BRIMM = 2'b11;  // immediate << 2 (branch target)

    localparam logic [1:0] PCSRC_ALU  = 2'b00;  // ALU result
    localparam logic [1:0] PCSRC_BR   = 2'b01;  // registered branch target
    localparam logic [1:0] PCSRC_JUMP = 2'b10;  // jump target

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_GT    = 2'b11;

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational decode of FSM state to datapath controls.
// Outputs depend only on the registered state (plus the branch/jump flavour
// flags captured in DECODE); the sole exceptions are the FETCH write strobes,
// which are qualified by mem_ready, and the reset override of all write
// strobes.
// Ports:
//   state            : current FSM state
//   is_bgt, is_jal   : registered instruction flavour for BRANCH / JUMP
//   mem_ready, reset : strobe qualifiers
//   remaining outputs: datapath strobes and selects
// Macro MULTICYCLE_CTRL_BGT_EN: when undefined branch_gt is tied to 0.
module ctrl_outdec
    import gh_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       is_bgt,
    input  logic       is_jal,
    input  logic       mem_ready,
    input  logic       reset,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic       branch,
    output logic       branch_gt,
    output logic       link,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop
);

`ifndef MULTICYCLE_CTRL_BGT_EN
    logic unused_is_bgt;
    assign unused_is_bgt = is_bgt;
`endif

    always_comb begin
        mem_req   = 1'b0;
        iord      = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        alusrca   = 1'b0;
        branch    = 1'b0;
        branch_gt = 1'b0;
        link      = 1'b0;
        illegal   = 1'b0;
        alusrcb   = SRCB_REG;
        pcsrc     = PCSRC_ALU;
        aluop     = ALUOP_ADD;

        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                // Latch the instruction and advance PC only on the cycle
                // memory actually delivers it.
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_BRIMM;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                mem_req = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                // Write held for the whole access, wait cycles included.
                iord     = 1'b1;
                mem_req  = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                branch  = 1'b1;
                pcsrc   = PCSRC_BR;
`ifdef MULTICYCLE_CTRL_BGT_EN
                if (is_bgt) begin
                    aluop     = ALUOP_GT;
                    branch_gt = 1'b1;
                end else begin
                    aluop     = ALUOP_SUB;
                end
`else
                aluop   = ALUOP_SUB;
`endif
            end
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                if (is_jal) begin
                    link     = 1'b1;
                    regwrite = 1'b1;
                end
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: ;
        endcase

        // Architectural writes are suppressed for as long as reset is held.
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback for an 8-opcode ISA.
// Ports:
//   clk, reset (sync, active-high), op (opcode), mem_ready (access done)
//   mem_req, iord, irwrite, pcwrite, memwrite, regwrite, memtoreg, regdst,
//   alusrca, branch, branch_gt, link, illegal : 1-bit strobes/selects
//   alusrcb, pcsrc, aluop : 2-bit selects
//   state : current FSM state (debug)
// Macro MULTICYCLE_CTRL_BGT_EN: defined -> op=100 executes as BGT;
// undefined -> op=100 traps through the ILLEGAL state.
module multicycle_ctrl
    import gh_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic       branch,
    output logic       branch_gt,
    output logic       link,
    output logic       illegal,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    state_e state_q, state_d;
    // Branch/jump flavour captured in DECODE so BRANCH/JUMP never look at op.
    logic   is_bgt_q, is_bgt_d;
    logic   is_jal_q, is_jal_d;

    always_comb begin
        state_d  = state_q;
        is_bgt_d = is_bgt_q;
        is_jal_d = is_jal_q;

        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                is_bgt_d = (op == OP_BGT);
                is_jal_d = (op == OP_JAL);
                unique case (op)
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_ADDI:        state_d = S_ADDIEX;
                    OP_BEQ:         state_d = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BGT_EN
                    OP_BGT:         state_d = S_BRANCH;
`else
                    OP_BGT:         state_d = S_ILLEGAL;
`endif
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:    state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_ADDIWB,
            S_BRANCH,
            S_JUMP,
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            is_bgt_q <= 1'b0;
            is_jal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_bgt_q <= is_bgt_d;
            is_jal_q <= is_jal_d;
        end
    end

    assign state = state_q;

    ctrl_outdec u_outdec (
        .state     (state_q),
        .is_bgt    (is_bgt_q),
        .is_jal    (is_jal_q),
        .mem_ready (mem_ready),
        .reset     (reset),
        .mem_req   (mem_req),
        .iord      (iord),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .alusrca   (alusrca),
        .branch    (branch),
        .branch_gt (branch_gt),
        .link      (link),
        .illegal   (illegal),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .aluop     (aluop)
    );

endmodule
